fsm_key_loader: RTL

Key-delivery stage that sits directly upstream of the locked controller FSMs in the benchmark set (e.g. the e161-class machines with duplicated, key-selected states). It receives the locking key serially from a tamper-resistant store, checks an even-parity bit, and presents the key in parallel on `key_out`, which feeds the controller's `keyinput*` pins. The controller is held in reset until a key has passed the parity check.

---
 rtl/fsm_key_pkg.sv | 14 +
 rtl/key_shift_reg.sv | 54 +++++
 rtl/fsm_key_loader.sv | 94 +++++++++
 3 files changed

// File: rtl/fsm_key_pkg.sv
// fsm_key_pkg: shared state encoding and default key width for the key loader
package fsm_key_pkg;

    localparam int KEY_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CHECK,
        LOCKED,
        ERROR
    } key_ld_state_t;

endpackage

// File: rtl/key_shift_reg.sv
// key_shift_reg: shadow key register, bit counter and running even-parity accumulator
module key_shift_reg
    import fsm_key_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             clr,
    input  logic             sdi,
    output logic [KEY_W-1:0] shadow,
    output logic             parity_ok,
    output logic             done
);

    localparam int CNT_W = $clog2(KEY_W + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [KEY_W-1:0] shadow_q, shadow_d;
    logic             par_q;
    logic             last;

    // the counter sitting at KEY_W means the next accepted bit is the parity bit
    assign last      = cnt_q == CNT_W'(KEY_W);
    assign done      = shift_en && last;
    assign shadow    = shadow_q;
    assign parity_ok = ~par_q;

    // place the incoming bit at the index given by the counter; parity bit leaves shadow untouched
    always_comb begin
        shadow_d = shadow_q;
        for (int i = 0; i < KEY_W; i++)
            if (cnt_q == CNT_W'(i)) shadow_d[i] = sdi;
    end

    // clear has priority; the counter saturates at KEY_W, parity folds in every accepted bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            shadow_q <= '0;
            par_q    <= 1'b0;
        end else if (clr) begin
            cnt_q    <= '0;
            shadow_q <= '0;
            par_q    <= 1'b0;
        end else if (shift_en) begin
            shadow_q <= shadow_d;
            cnt_q    <= last ? cnt_q : cnt_q + CNT_W'(1);
            par_q    <= par_q ^ sdi;
        end
    end

endmodule

// File: rtl/fsm_key_loader.sv
// fsm_key_loader: serial key intake with parity check, gating the downstream controller reset
module fsm_key_loader
    import fsm_key_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_start,
    input  logic             key_sdi,
    input  logic             key_sin_valid,
    output logic             key_rdy,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             key_err,
    output logic             fsm_hold
);

    key_ld_state_t    state_q;
    logic [KEY_W-1:0] key_out_q;
    logic             key_valid_q, key_err_q, fsm_hold_q, key_rdy_q;
    logic [KEY_W-1:0] shadow;
    logic             parity_ok, done, shift_en, clr;

    // a restart request wins over a same-cycle serial bit; CHECK cannot be interrupted
    assign clr      = ld_start && state_q != CHECK;
    assign shift_en = state_q == SHIFT && key_sin_valid && !ld_start;

    assign key_rdy   = key_rdy_q;
    assign key_out   = key_out_q;
    assign key_valid = key_valid_q;
    assign key_err   = key_err_q;
    assign fsm_hold  = fsm_hold_q;

    key_shift_reg #(.KEY_W(KEY_W)) u_shift (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .clr      (clr),
        .sdi      (key_sdi),
        .shadow   (shadow),
        .parity_ok(parity_ok),
        .done     (done)
    );

    // load sequencing with all outputs registered; key_out only moves when CHECK resolves
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            key_out_q   <= '0;
            key_valid_q <= 1'b0;
            key_err_q   <= 1'b0;
            fsm_hold_q  <= 1'b1;
            key_rdy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (ld_start) begin
                    state_q   <= SHIFT;
                    key_rdy_q <= 1'b1;
                    key_err_q <= 1'b0;
                end
                SHIFT: if (!ld_start && done) begin
                    state_q   <= CHECK;
                    key_rdy_q <= 1'b0;
                end
                CHECK: begin
                    state_q     <= parity_ok ? LOCKED : ERROR;
                    key_out_q   <= parity_ok ? shadow : '0;
                    key_valid_q <= parity_ok;
                    key_err_q   <= !parity_ok;
                    fsm_hold_q  <= !parity_ok;
                end
                LOCKED: if (ld_start) begin
                    state_q     <= SHIFT;
                    key_rdy_q   <= 1'b1;
                    key_valid_q <= 1'b0;
                    fsm_hold_q  <= 1'b1;
                end
                ERROR: if (ld_start) begin
                    state_q   <= SHIFT;
                    key_rdy_q <= 1'b1;
                    key_err_q <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    key_rdy_q   <= 1'b0;
                    key_valid_q <= 1'b0;
                    fsm_hold_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule
